// File: rtl/dpram_port_client.sv
// Host-side client for one port of a dual-port RAM: valid/ready requests, 1-cycle read
// latency absorbed into a 2-entry response FIFO, optional fill sweep (DPRAM_CLIENT_CLEAR_EN).
module dpram_port_client #(
  parameter int unsigned           ADDRESS_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_wren,
  output logic [DATA_WIDTH-1:0]    ram_data,
  input  logic [DATA_WIDTH-1:0]    ram_q
);
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  logic                  serve_c;
  logic                  accept_c;
  logic                  rd_accept_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  credit_c;
  logic [CNT_W-1:0]      outstanding_c;
  logic                  in_flight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;

  assign push_c     = in_flight_q;
  assign pop_c      = resp_valid & resp_ready;
  assign resp_valid = (count_q != '0);
  assign resp_rdata = fifo_q[rd_ptr_q];

  // A slot freed by a same-cycle pop counts as available, sustaining one read per cycle.
  assign outstanding_c = CNT_W'(in_flight_q) + count_q - CNT_W'(pop_c);
  assign credit_c      = (outstanding_c < CNT_W'(FIFO_DEPTH));
  assign req_ready     = serve_c & (req_write | credit_c);
  assign accept_c      = req_valid & req_ready;
  assign rd_accept_c   = accept_c & ~req_write;
  assign count_d       = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_flight_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      in_flight_q <= rd_accept_c;
      if (push_c) begin
        fifo_q[wr_ptr_q] <= ram_q;
      end
      wr_ptr_q <= wr_ptr_q ^ push_c;
      rd_ptr_q <= rd_ptr_q ^ pop_c;
      count_q  <= count_d;
    end
  end

`ifdef DPRAM_CLIENT_CLEAR_EN
  typedef enum logic {ST_SERVE = 1'b0, ST_CLEAR = 1'b1} state_e;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  state_e                   state_q;
  state_e                   state_d;
  logic [ADDRESS_WIDTH-1:0] sweep_q;
  logic [ADDRESS_WIDTH-1:0] sweep_d;
  logic                     done_q;
  logic                     done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SERVE;
      sweep_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      done_q  <= done_d;
    end
  end

  // Sweep walks every address once; the counter wraps back to 0 on the last write.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    done_d      = 1'b0;
    ram_address = req_addr;
    ram_data    = req_wdata;
    ram_wren    = accept_c & req_write;
    case (state_q)
      ST_SERVE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ram_address = sweep_q;
        ram_data    = CLEAR_VALUE;
        ram_wren    = 1'b1;
        sweep_d     = sweep_q + ADDRESS_WIDTH'(1);
        if (sweep_q == LAST_ADDR) begin
          state_d = ST_SERVE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  assign serve_c    = (state_q == ST_SERVE);
  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;
`else
  logic unused_clear;

  assign unused_clear = clear_start ^ (^CLEAR_VALUE);
  assign serve_c      = 1'b1;
  assign ram_address  = req_addr;
  assign ram_data     = req_wdata;
  assign ram_wren     = accept_c & req_write;
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_port_client.sv
// Bench for dpram_port_client: attached 1-cycle RAM, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dpram_port_client;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam logic [DW-1:0] CV  = 8'hFF;
`ifdef DPRAM_CLIENT_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  dpram_port_client #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Attached RAM port: synchronous write, read data one cycle after the address edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: expected RAM contents, reads awaiting delivery, sweep progress.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_ready_q [$];
  bit            m_pend = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  bit            m_clr = 1'b0;
  int            m_clr_addr = 0;
  bit            m_done = 1'b0;
  bit            m_acc, m_pop;

  // Undelivered reads after this edge may never exceed the two response slots.
  function automatic bit exp_ready();
    int after_edge;
    after_edge = int'(m_pend) + m_ready_q.size()
               - ((m_ready_q.size() > 0 && resp_ready) ? 1 : 0) + 1;
    return !m_clr && (req_write || after_edge <= 2);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ready_q.delete();
      m_pend = 1'b0;
      m_clr = 1'b0;
      m_clr_addr = 0;
      m_done = 1'b0;
    end else begin
      m_acc = req_valid && exp_ready();
      m_pop = m_ready_q.size() > 0 && resp_ready;
      if (m_pop) void'(m_ready_q.pop_front());
      if (m_pend) m_ready_q.push_back(m_pend_data);
      m_pend = 1'b0;
      m_done = 1'b0;
      if (m_acc) begin
        if (req_write) m_mem[req_addr] = req_wdata;
        else begin
          m_pend = 1'b1;
          m_pend_data = m_mem[req_addr];
        end
      end
      if (m_clr) begin
        m_mem[m_clr_addr] = CV;
        if (m_clr_addr == DEPTH - 1) begin
          m_clr = 1'b0;
          m_done = 1'b1;
          m_clr_addr = 0;
        end else m_clr_addr++;
      end else if (CLR_EN && clear_start) begin
        m_clr = 1'b1;
      end
    end
  end

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clock) begin
    check("resp_valid", 32'(resp_valid), 32'(m_ready_q.size() > 0));
    if (m_ready_q.size() > 0) check("resp_rdata", 32'(resp_rdata), 32'(m_ready_q[0]));
    check("req_ready", 32'(req_ready), 32'(exp_ready()));
    check("clear_busy", 32'(clear_busy), 32'(m_clr));
    check("clear_done", 32'(clear_done), 32'(m_done));
    if (m_clr) begin
      check("sweep_wren", 32'(ram_wren), 32'd1);
      check("sweep_addr", 32'(ram_address), 32'(m_clr_addr));
      check("sweep_data", 32'(ram_data), 32'(CV));
    end else begin
      check("ram_wren", 32'(ram_wren), 32'(req_valid && exp_ready() && req_write));
      if (ram_wren) begin
        check("ram_addr", 32'(ram_address), 32'(req_addr));
        check("ram_data", 32'(ram_data), 32'(req_wdata));
      end
    end
  end

  // Collected responses for the literal checks in the scenarios.
  logic [DW-1:0] got_q [$];
  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) got_q.push_back(resp_rdata);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!ok && n < 50) begin
      @(negedge clock);
      ok = req_ready;
      tick();
      n++;
    end
    check("send_accept", 32'(ok), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic expect_got(input string name, input int idx, input logic [DW-1:0] exp);
    logic [DW-1:0] v;
    v = (idx < got_q.size()) ? got_q[idx] : 'x;
    check(name, 32'(v), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Write then read back; data appears the edge after the read is accepted.
    send(1'b1, 4'd3, 8'h5A);
    send(1'b0, 4'd3, 8'h00);
    check("t1_valid_at_accept", 32'(resp_valid), 32'd0);
    tick();
    check("t1_valid_next", 32'(resp_valid), 32'd1);
    check("t1_rdata", 32'(resp_rdata), 32'h5A);
    repeat (3) tick();

    // Back-to-back reads at full rate.
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), DW'(8'h10 + i));
    got_q.delete();
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      @(negedge clock);
      check("t2_ready", 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    check("t2_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) expect_got("t2_data", i, DW'(8'h10 + i));

    // Back-pressure: two reads fill the credit, writes still pass.
    got_q.delete();
    resp_ready = 1'b0;
    send(1'b0, 4'd0, 8'h00);
    send(1'b0, 4'd1, 8'h00);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t3_read_blocked", 32'(req_ready), 32'd0);
      tick();
    end
    req_write = 1'b1;
    req_addr  = 4'd8;
    req_wdata = 8'h77;
    @(negedge clock);
    check("t3_write_ok", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    send(1'b0, 4'd2, 8'h00);
    send(1'b0, 4'd8, 8'h00);
    repeat (4) tick();
    check("t3_count", 32'(got_q.size()), 32'd4);
    expect_got("t3_data0", 0, 8'h10);
    expect_got("t3_data1", 1, 8'h11);
    expect_got("t3_data2", 2, 8'h12);
    expect_got("t3_data3", 3, 8'h77);

`ifdef DPRAM_CLIENT_CLEAR_EN
    begin
      int busy_n, wren_n, done_n;
      busy_n = 0;
      wren_n = 0;
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
        clear_start = (c == 0 || c == 6);
        @(negedge clock);
        if (clear_busy) busy_n++;
        if (clear_busy && ram_wren) wren_n++;
        if (clear_done) done_n++;
        tick();
      end
      clear_start = 1'b0;
      check("t4_busy_cycles", 32'(busy_n), 32'd16);
      check("t4_wren_cycles", 32'(wren_n), 32'd16);
      check("t4_done_pulses", 32'(done_n), 32'd1);
    end
    got_q.delete();
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), 8'h00);
    repeat (4) tick();
    check("t4_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) expect_got("t4_data", i, 8'hFF);

    // Reset while address 7 is presented aborts the sweep before that write.
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(8'h30 + i));
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 30 && !hit; c++) begin
        @(negedge clock);
        if (clear_busy && ram_address == AW'(7)) hit = 1'b1;
        else tick();
      end
      check("t5_reached_7", 32'(hit), 32'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("t5_busy_rst", 32'(clear_busy), 32'd0);
    check("t5_wren_rst", 32'(ram_wren), 32'd0);
    check("t5_done_rst", 32'(clear_done), 32'd0);
    check("t5_valid_rst", 32'(resp_valid), 32'd0);
    repeat (2) tick();
    @(negedge clock);
    #1 reset_n = 1'b1;
    tick();
    got_q.delete();
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), 8'h00);
    repeat (4) tick();
    check("t5_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) expect_got("t5_data", i, (i < 7) ? 8'hFF : DW'(8'h30 + i));
`else
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("t6_busy", 32'(clear_busy), 32'd0);
      check("t6_done", 32'(clear_done), 32'd0);
      tick();
    end
    got_q.delete();
    send(1'b1, 4'd5, 8'hC3);
    send(1'b0, 4'd5, 8'h00);
    repeat (3) tick();
    check("t6_count", 32'(got_q.size()), 32'd1);
    expect_got("t6_data", 0, 8'hC3);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
